// File: rtl/seqdet_param.sv
// Parametrised serial sequence detector: flags each occurrence of PATTERN in a
// qualified bit stream, with selectable overlap and Mealy/Moore output timing.
module seqdet_param #(
  parameter int             N       = 5,
  parameter logic [N-1:0]   PATTERN = 5'b10010,
  parameter bit             OVERLAP = 1'b1,
  parameter bit             MOORE   = 1'b0,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             din,
  input  logic             din_vld,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int            FW       = $clog2(N);
  localparam logic [FW-1:0] FILL_MAX = FW'(N - 1);

  logic [N-2:0]     hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             dout_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     window;
  logic             hit;

  // Oldest history bit lands in the MSB, matching PATTERN's first-received bit.
  assign window = {hist_q, din};
  assign hit    = din_vld && (fill_q == FILL_MAX) && (window == PATTERN);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (din_vld) begin
      if (hit && !OVERLAP) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[N-2:0];
        fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hist_q <= '0;
      fill_q <= '0;
      dout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      dout_q <= hit;
      cnt_q  <= cnt_d;
    end
  end

  assign dout      = MOORE ? dout_q : hit;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seqdet_param.sv
// Directed bench for seqdet_param: four instances cover overlap/non-overlap,
// Mealy/Moore timing and counter saturation with hand-computed expectations.
module tb_seqdet_param;

  logic clk = 1'b0;
  logic clr;
  logic din, din_vld, cnt_clr;
  logic s_din, s_vld, s_cnt_clr;

  logic       ov_dout, no_dout, mo_dout, sat_dout;
  logic [7:0] ov_cnt, no_cnt, mo_cnt;
  logic [1:0] sat_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seqdet_param u_ov (
    .clk(clk), .clr(clr), .din(din), .din_vld(din_vld), .cnt_clr(cnt_clr),
    .dout(ov_dout), .match_cnt(ov_cnt)
  );

  seqdet_param #(.OVERLAP(1'b0)) u_no (
    .clk(clk), .clr(clr), .din(din), .din_vld(din_vld), .cnt_clr(cnt_clr),
    .dout(no_dout), .match_cnt(no_cnt)
  );

  seqdet_param #(.MOORE(1'b1)) u_mo (
    .clk(clk), .clr(clr), .din(din), .din_vld(din_vld), .cnt_clr(cnt_clr),
    .dout(mo_dout), .match_cnt(mo_cnt)
  );

  seqdet_param #(.N(2), .PATTERN(2'b11), .CNT_W(2)) u_sat (
    .clk(clk), .clr(clr), .din(s_din), .din_vld(s_vld), .cnt_clr(s_cnt_clr),
    .dout(sat_dout), .match_cnt(sat_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  // Inputs change on the falling edge; Mealy outputs are sampled 2 ns later.
  task automatic drive(input logic d, input logic v);
    @(negedge clk);
    din     = d;
    din_vld = v;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    din_vld = 1'b0;
    s_vld   = 1'b0;
    clr     = 1'b1;
    @(negedge clk);
    clr     = 1'b0;
  endtask

  logic [7:0] stream8;
  logic [4:0] stream5;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; din = 1'b0; din_vld = 1'b0; cnt_clr = 1'b0;
    s_din = 1'b0; s_vld = 1'b0; s_cnt_clr = 1'b0;
    stream8 = 8'b1001_0010;
    stream5 = 5'b10010;

    // Reset held with valid toggling data: nothing may leak out.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      din = ~din; din_vld = 1'b1; s_din = ~s_din; s_vld = 1'b1;
      #1;
      check($sformatf("rst ov_dout %0d", i), ov_dout, 0);
      check($sformatf("rst mo_dout %0d", i), mo_dout, 0);
      check($sformatf("rst ov_cnt %0d", i), ov_cnt, 0);
    end
    @(negedge clk);
    clr = 1'b0; din_vld = 1'b0; s_vld = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(i[0], 1'b0);
      check($sformatf("idle ov_dout %0d", i), ov_dout, 0);
      tick();
      check($sformatf("idle mo_dout %0d", i), mo_dout, 0);
    end
    check("idle ov_cnt", ov_cnt, 0);

    // Stream 1,0,0,1,0,0,1,0 through all three PATTERN instances.
    for (int i = 0; i < 8; i++) begin
      drive(stream8[7-i], 1'b1);
      check($sformatf("s8 ov_dout b%0d", i + 1), ov_dout, (i == 4 || i == 7) ? 1 : 0);
      check($sformatf("s8 no_dout b%0d", i + 1), no_dout, (i == 4) ? 1 : 0);
      check($sformatf("s8 mo_dout b%0d", i + 1), mo_dout, (i == 5) ? 1 : 0);
      tick();
    end
    check("s8 ov_cnt", ov_cnt, 2);
    check("s8 no_cnt", no_cnt, 1);
    check("s8 mo_cnt", mo_cnt, 2);
    check("s8 mo_dout after b8 edge", mo_dout, 1);
    drive(1'b1, 1'b0);
    check("mo_dout bubble cycle", mo_dout, 1);
    tick();
    check("mo_dout pulse ends", mo_dout, 0);

    // Continue with 1,0,0,1,0: each instance matches on the fifth new bit.
    for (int i = 0; i < 5; i++) begin
      drive(stream5[4-i], 1'b1);
      check($sformatf("s5 ov_dout b%0d", i + 1), ov_dout, (i == 4) ? 1 : 0);
      check($sformatf("s5 no_dout b%0d", i + 1), no_dout, (i == 4) ? 1 : 0);
      check($sformatf("s5 mo_dout b%0d", i + 1), mo_dout, 0);
      tick();
    end
    check("s5 ov_cnt", ov_cnt, 3);
    check("s5 no_cnt", no_cnt, 2);
    check("s5 mo_cnt", mo_cnt, 3);
    check("s5 mo_dout after edge", mo_dout, 1);

    // Synchronous counter clear on the shared group.
    @(negedge clk);
    din_vld = 1'b0; cnt_clr = 1'b1;
    tick();
    check("cnt_clr ov_cnt", ov_cnt, 0);
    check("cnt_clr mo_dout", mo_dout, 0);
    @(negedge clk);
    cnt_clr = 1'b0;

    // Bubbles between every bit of 1,0,0,1,0.
    pulse_clr();
    for (int i = 0; i < 5; i++) begin
      drive(stream5[4-i], 1'b1);
      check($sformatf("gap ov_dout b%0d", i + 1), ov_dout, (i == 4) ? 1 : 0);
      tick();
      drive(~stream5[4-i], 1'b0);
      check($sformatf("gap ov_dout bubble%0d", i + 1), ov_dout, 0);
      tick();
    end
    check("gap ov_cnt", ov_cnt, 1);

    // Reset after bit 3 of the 8-bit stream erases the partial 100 prefix.
    pulse_clr();
    for (int i = 0; i < 3; i++) begin
      drive(stream8[7-i], 1'b1);
      tick();
    end
    pulse_clr();
    check("midrst ov_cnt", ov_cnt, 0);
    for (int i = 3; i < 8; i++) begin
      drive(stream8[7-i], 1'b1);
      check($sformatf("midrst ov_dout b%0d", i + 1), ov_dout, (i == 7) ? 1 : 0);
      tick();
    end
    check("midrst ov_cnt end", ov_cnt, 1);

    // N=2 all-ones pattern: consecutive hits and 2-bit counter saturation.
    pulse_clr();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      s_din = 1'b1; s_vld = 1'b1; s_cnt_clr = 1'b0;
      #2;
      check($sformatf("sat dout b%0d", k), sat_dout, (k >= 2) ? 1 : 0);
      tick();
      check($sformatf("sat cnt b%0d", k), sat_cnt, (k - 1 > 3) ? 3 : k - 1);
    end
    @(negedge clk);
    s_din = 1'b1; s_vld = 1'b1; s_cnt_clr = 1'b1;
    #2;
    check("sat dout with clr", sat_dout, 1);
    tick();
    check("sat cnt clr wins", sat_cnt, 0);
    @(negedge clk);
    s_cnt_clr = 1'b0;
    tick();
    check("sat cnt after clr", sat_cnt, 1);
    @(negedge clk);
    s_vld = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seqdet_param.md
Name: seqdet_param

Overview:
Parametrised serial sequence detector, the successor to the fixed-pattern Mealy detector. It watches a qualified 1-bit serial stream and flags each occurrence of a compile-time PATTERN of length N. Overlap or non-overlap detection and Mealy or Moore output timing are selected by parameter. A saturating match counter is included for lab and board observation.

Parameters:
N, 5, pattern length in bits; legal range 2..16.
PATTERN, 5'b10010, target sequence (N bits); MSB is the first bit received.
OVERLAP, 1, 1 = a match's tail bits may start the next match; 0 = history is discarded after each match.
MOORE, 0, 0 = Mealy (dout combinational, same cycle as last bit); 1 = Moore (dout registered, one cycle later).
CNT_W, 8, width of the match counter.

Ports:
clk  input  1  rising-edge clock
clr  input  1  asynchronous active-high reset
din  input  1  serial data bit
din_vld  input  1  din is sampled only when high
cnt_clr  input  1  synchronous clear of match_cnt
dout  output  1  match flag
match_cnt  output  CNT_W  saturating count of matches

Behaviour:
- Reset: clr=1 asynchronously forces hist=0, fill=0, dout_r=0, match_cnt=0, so dout=0 in both modes. Clear releases at any time; the first valid bit after release is treated as bit 1 of a fresh stream.
- State:
  - hist[N-2:0]: last N-1 accepted bits, newest in the LSB.
  - fill: count of accepted bits held in hist, saturating at N-1, width ceil(log2(N)).
- Combinational hit = din_vld & (fill==N-1) & ({hist,din}==PATTERN). No match is possible until N valid bits have been seen since reset or the last non-overlap match.
- On a clock edge with din_vld=1:
  - hit=0: hist <= {hist[N-3:0],din} (for N=2: hist <= din); fill <= min(fill+1, N-1).
  - hit=1, OVERLAP=1: same shift as hit=0.
  - hit=1, OVERLAP=0: hist <= 0, fill <= 0.
- On a clock edge with din_vld=0: hist and fill hold; hit=0.
- Output:
  - MOORE=0: dout = hit (combinational). It may glitch with din, so consumers sample dout at the clock edge.
  - MOORE=1: dout_r <= hit on every edge. dout = dout_r, high for exactly one cycle after the accepting edge, even if din_vld is then low.
- match_cnt, updated each edge:
  - cnt_clr=1: match_cnt <= 0. Clear wins over a simultaneous hit.
  - else if hit and match_cnt != all-ones: match_cnt increments.
  - At all-ones it holds (saturates).
- Back-to-back matches: OVERLAP=1 allows a match every N-k bits, where k is the longest proper border of PATTERN. Consecutive hit cycles are legal (e.g. PATTERN all-ones gives a hit every valid bit).
- Single clock domain. din, din_vld and cnt_clr are synchronous to clk. No internal synchronisers.

Test Plan:
1. Reset/idle: clr=1 for 50 ns with din toggling -> dout=0, match_cnt=0 throughout. After release with din_vld=0 for 10 cycles -> no state change, dout=0.
2. Overlap, Mealy (defaults): valid stream 1,0,0,1,0,0,1,0 -> dout high during bit 5 and bit 8 cycles only; match_cnt=2 after bit 8.
3. Non-overlap: OVERLAP=0, same stream -> dout high on bit 5 only; match_cnt=1. Then send 1,0,0,1,0 -> second match on the 5th new bit; match_cnt=2.
4. Moore timing: MOORE=1, stream 1,0,0,1,0 -> dout=0 during bit 5, high exactly the cycle after the bit-5 edge, low after. Repeat with din_vld=0 following bit 5 -> same one-cycle pulse.
5. Gaps and mid-stream reset: insert din_vld=0 bubbles between every bit of 1,0,0,1,0 -> match still detected on bit 5. Pulse clr after bit 3 of 1,0,0,1,0,0,1,0 -> history lost; no match until 5 new valid bits form 10010.
6. Counter edges: CNT_W=2, N=2, PATTERN=2'b11, 8 valid ones -> match_cnt 0,1,2,3,3 (saturates). cnt_clr=1 in the same cycle as a hit -> match_cnt=0 next cycle.
